// File: rtl/deemph_stereo_sched.sv
// Purpose:  shared first-order IIR de-emphasis for L/R audio; one multiplier,
//           round-robin arbitration of the two input FIFOs, per-channel history.
// Latency:  rd_en in cycle t -> wr_en (with dout) in cycle t+5; one sample per 6 cycles total.
// Backpressure: stalls in WRITE while the granted channel's output FIFO is full;
//           no input is popped and history is not updated until the write lands.
//
// Ports:
//   clock, reset                       rising-edge clock, synchronous active-high reset
//   din_l/l_in_empty/l_in_rd_en        left input FIFO (first-word fall-through)
//   din_r/r_in_empty/r_in_rd_en        right input FIFO
//   dout_l/l_out_full/l_out_wr_en      left output FIFO (dout registered, held between writes)
//   dout_r/r_out_full/r_out_wr_en      right output FIFO
//   busy                               high in every state except IDLE
// Optional feature: DEEMPH_PRIME_EN -- emit one leading zero per channel after reset.

module deemph_stereo_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int B_COEF     = 178,
  parameter int A_COEF     = -666
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_l,
  input  logic                  l_in_empty,
  output logic                  l_in_rd_en,
  input  logic [DATA_WIDTH-1:0] din_r,
  input  logic                  r_in_empty,
  output logic                  r_in_rd_en,
  output logic [DATA_WIDTH-1:0] dout_l,
  input  logic                  l_out_full,
  output logic                  l_out_wr_en,
  output logic [DATA_WIDTH-1:0] dout_r,
  input  logic                  r_out_full,
  output logic                  r_out_wr_en,
  output logic                  busy
);

  localparam int P_W = 2 * DATA_WIDTH;
  localparam logic signed [P_W-1:0] B_EXT = P_W'(B_COEF);
  localparam logic signed [P_W-1:0] A_EXT = P_W'(A_COEF);
  // Added to negative products before the arithmetic shift so the
  // quotient truncates toward zero instead of toward minus infinity.
  localparam logic signed [P_W-1:0] RND = (P_W'(1) <<< FRAC_BITS) - P_W'(1);

  typedef enum logic [2:0] {
    IDLE, MUL0, MUL1, MUL2, SUM, WRITE
`ifdef DEEMPH_PRIME_EN
    , PRIME_L, PRIME_R
`endif
  } state_t;

`ifdef DEEMPH_PRIME_EN
  localparam state_t RESET_STATE = PRIME_L;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state, state_nxt;

  logic                         ch;          // 0 = left, 1 = right
  logic                         last_grant;  // 0 = left, 1 = right
  logic signed [DATA_WIDTH-1:0] x, y, t0, t1;
  logic signed [P_W-1:0]        p;
  logic signed [DATA_WIDTH-1:0] x1_l, y1_l, x1_r, y1_r;

  logic elig_l, elig_r, grant, grant_r, out_full_ch;

  function automatic logic signed [DATA_WIDTH-1:0] dq(input logic signed [P_W-1:0] prod);
    logic signed [P_W-1:0] adj;
    adj = prod[P_W-1] ? prod + RND : prod;
    return DATA_WIDTH'(adj >>> FRAC_BITS);
  endfunction

  assign elig_l      = !l_in_empty && !l_out_full;
  assign elig_r      = !r_in_empty && !r_out_full;
  assign out_full_ch = ch ? r_out_full : l_out_full;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_r   = 1'b0;
    case (state)
      IDLE: begin
        if (elig_l || elig_r) begin
          grant     = 1'b1;
          // Both eligible: alternate away from the last winner.
          grant_r   = (elig_l && elig_r) ? ~last_grant : elig_r;
          state_nxt = MUL0;
        end
      end
      MUL0:  state_nxt = MUL1;
      MUL1:  state_nxt = MUL2;
      MUL2:  state_nxt = SUM;
      SUM:   state_nxt = WRITE;
      WRITE: if (!out_full_ch) state_nxt = IDLE;
`ifdef DEEMPH_PRIME_EN
      PRIME_L: if (!l_out_full) state_nxt = PRIME_R;
      PRIME_R: if (!r_out_full) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      l_in_rd_en  <= 1'b0;
      r_in_rd_en  <= 1'b0;
      l_out_wr_en <= 1'b0;
      r_out_wr_en <= 1'b0;
      dout_l      <= '0;
      dout_r      <= '0;
      ch          <= 1'b0;
      last_grant  <= 1'b1;
      x           <= '0;
      y           <= '0;
      t0          <= '0;
      t1          <= '0;
      p           <= '0;
      x1_l        <= '0;
      y1_l        <= '0;
      x1_r        <= '0;
      y1_r        <= '0;
    end else begin
      // Pops are registered, so they land one cycle after din was latched;
      // IDLE is not revisited before the FIFO flags have settled.
      l_in_rd_en  <= grant && !grant_r;
      r_in_rd_en  <= grant && grant_r;
      l_out_wr_en <= 1'b0;
      r_out_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            ch         <= grant_r;
            last_grant <= grant_r;
            x          <= grant_r ? din_r : din_l;
          end
        end
        MUL0: p <= B_EXT * P_W'(x);
        MUL1: begin
          t0 <= dq(p);
          p  <= B_EXT * P_W'(ch ? x1_r : x1_l);
        end
        MUL2: begin
          t1 <= dq(p);
          p  <= A_EXT * P_W'(ch ? y1_r : y1_l);
        end
        SUM: y <= t0 + t1 + dq(p);
        WRITE: begin
          if (!out_full_ch) begin
            if (ch) begin
              dout_r      <= y;
              r_out_wr_en <= 1'b1;
              x1_r        <= x;
              y1_r        <= y;
            end else begin
              dout_l      <= y;
              l_out_wr_en <= 1'b1;
              x1_l        <= x;
              y1_l        <= y;
            end
          end
        end
`ifdef DEEMPH_PRIME_EN
        PRIME_L: begin
          if (!l_out_full) begin
            dout_l      <= '0;
            l_out_wr_en <= 1'b1;
          end
        end
        PRIME_R: begin
          if (!r_out_full) begin
            dout_r      <= '0;
            r_out_wr_en <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deemph_stereo_sched.sv
module tb_deemph_stereo_sched;

  localparam int DW = 32;
`ifdef DEEMPH_PRIME_EN
  localparam int PRIME = 1;
`else
  localparam int PRIME = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] din_l, din_r, dout_l, dout_r;
  logic          l_in_empty, r_in_empty, l_in_rd_en, r_in_rd_en;
  logic          l_out_full = 1'b0, r_out_full = 1'b0;
  logic          l_out_wr_en, r_out_wr_en, busy;

  int q_l[$], q_r[$];
  int out_l[$], out_r[$];
  int rd_ch[$], rd_cyc[$], wr_cyc_l[$], wr_cyc_r[$];
  int cyc = 0, n_wr_l = 0, n_wr_r = 0;
  int n_checks = 0, n_fail = 0;
  int mx1[2], my1[2];

  assign din_l      = (q_l.size() > 0) ? q_l[0] : 0;
  assign din_r      = (q_r.size() > 0) ? q_r[0] : 0;
  assign l_in_empty = (q_l.size() == 0);
  assign r_in_empty = (q_r.size() == 0);

  deemph_stereo_sched dut (
    .clock(clock), .reset(reset),
    .din_l(din_l), .l_in_empty(l_in_empty), .l_in_rd_en(l_in_rd_en),
    .din_r(din_r), .r_in_empty(r_in_empty), .r_in_rd_en(r_in_rd_en),
    .dout_l(dout_l), .l_out_full(l_out_full), .l_out_wr_en(l_out_wr_en),
    .dout_r(dout_r), .r_out_full(r_out_full), .r_out_wr_en(r_out_wr_en),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // FIFO models and output capture, sampled on the falling edge.
  always @(negedge clock) begin
    cyc++;
    if (l_in_rd_en) begin
      if (q_l.size() > 0) void'(q_l.pop_front());
      rd_ch.push_back(0);
      rd_cyc.push_back(cyc);
    end
    if (r_in_rd_en) begin
      if (q_r.size() > 0) void'(q_r.pop_front());
      rd_ch.push_back(1);
      rd_cyc.push_back(cyc);
    end
    if (l_out_wr_en) begin
      out_l.push_back(int'(dout_l));
      wr_cyc_l.push_back(cyc);
      n_wr_l++;
    end
    if (r_out_wr_en) begin
      out_r.push_back(int'(dout_r));
      wr_cyc_r.push_back(cyc);
      n_wr_r++;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // which: 0 = left outputs, 1 = right outputs, 2 = input pops
  function automatic int log_size(input int which);
    if (which == 0) return out_l.size();
    if (which == 1) return out_r.size();
    return rd_ch.size();
  endfunction

  task automatic wait_for(input string tag, input int which, input int n);
    int k = 0;
    while (log_size(which) < n && k < 300) begin
      tick(1);
      k++;
    end
    check(tag, longint'(log_size(which) >= n), 1);
  endtask

  // Independent reference: integer division truncates toward zero.
  function automatic int dqm(input longint prod);
    return int'(prod / 1024);
  endfunction

  function automatic int model(input int c, input int x);
    int y;
    y = dqm(178 * longint'(x)) + dqm(178 * longint'(mx1[c])) + dqm(-666 * longint'(my1[c]));
    mx1[c] = x;
    my1[c] = y;
    return y;
  endfunction

  task automatic clear_logs();
    out_l.delete(); out_r.delete(); rd_ch.delete(); rd_cyc.delete();
    wr_cyc_l.delete(); wr_cyc_r.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    check("rst_l_rd", l_in_rd_en, 0);
    check("rst_r_rd", r_in_rd_en, 0);
    check("rst_l_wr", l_out_wr_en, 0);
    check("rst_r_wr", r_out_wr_en, 0);
    check("rst_dout_l", dout_l, 0);
    check("rst_dout_r", dout_r, 0);
    check("rst_busy", busy, PRIME);
    tick(1);
    reset = 1'b0;
    mx1 = '{0, 0};
    my1 = '{0, 0};
    clear_logs();
`ifdef DEEMPH_PRIME_EN
    wait_for("prime_l_wait", 0, 1);
    wait_for("prime_r_wait", 1, 1);
    check("prime_l_zero", out_l[0], 0);
    check("prime_r_zero", out_r[0], 0);
    check("prime_order", longint'(wr_cyc_l[0] < wr_cyc_r[0]), 1);
    check("prime_no_rd", rd_ch.size(), 0);
    tick(2);
    clear_logs();
`endif
  endtask

  initial begin
    int vl[4], vr[4], el, er, wr0, rd0;
    vl = '{1000, -2000, 3000, 500000};
    vr = '{-7, 123456, -1, 0};

    tick(2);
    do_reset();

    // Left step response
    q_l.push_back(1024);
    q_l.push_back(1024);
    wait_for("step_wait", 0, 2);
    check("step_y0", out_l[0], 178);
    check("step_y1", out_l[1], 241);
    check("step_latency", wr_cyc_l[0] - rd_cyc[0], 5);
    check("step_r_quiet", out_r.size(), 0);
    check("step_rd_count", rd_ch.size(), 2);
    void'(model(0, 1024));
    void'(model(0, 1024));

    // Truncation toward zero on the right channel
    clear_logs();
    q_r.push_back(-1);
    wait_for("trunc_wait0", 1, 1);
    check("trunc_m1", out_r[0], 0);
    void'(model(1, -1));
    q_r.push_back(-2048);
    wait_for("trunc_wait1", 1, 2);
    check("trunc_m2048", out_r[1], -356);
    void'(model(1, -2048));

    // Round robin from a fresh reset, both FIFOs preloaded
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q_l.push_back(vl[i]);
      q_r.push_back(vr[i]);
    end
    wait_for("rr_wait_l", 0, 4);
    wait_for("rr_wait_r", 1, 4);
    for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), rd_ch[i], i % 2);
    for (int i = 0; i < 7; i++) check($sformatf("rr_gap%0d", i), rd_cyc[i+1] - rd_cyc[i], 6);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_l%0d", i), out_l[i], model(0, vl[i]));
      check($sformatf("rr_r%0d", i), out_r[i], model(1, vr[i]));
    end

    // Back-pressure on the left output while a right sample waits
    clear_logs();
    q_l.push_back(2048);
    q_r.push_back(4096);
    wait_for("bp_rd_wait", 2, 1);
    l_out_full = 1'b1;
    wr0 = n_wr_l;
    rd0 = rd_ch.size();
    tick(14);
    check("bp_no_wr", n_wr_l, wr0);
    check("bp_no_rd", rd_ch.size(), rd0);
    check("bp_busy", busy, 1);
    l_out_full = 1'b0;
    wait_for("bp_wr_wait", 0, 1);
    el = model(0, 2048);
    check("bp_value", out_l[0], el);
    check("bp_one_wr", out_l.size(), 1);
    wait_for("bp_r_wait", 1, 1);
    er = model(1, 4096);
    check("bp_r_value", out_r[0], er);
    check("bp_r_after", rd_ch[1], 1);

    // Reset asserted while the left sample is in MUL2
    clear_logs();
    q_l.push_back(1024);
    wait_for("mid_rd_wait", 2, 1);
    tick(1);
    wr0 = n_wr_l;
    do_reset();
    tick(8);
    check("mid_no_wr", n_wr_l, wr0 + PRIME);
    q_l.push_back(1024);
    wait_for("mid_wait", 0, 1);
    check("mid_after", out_l[0], 178);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
